syn_pipe_stage: RTL

- Parametrised pipeline-stage register for the pipelined core.
- Replaces fixed per-stage enable registers (fixed field list, enable-only hold) with one generic block:
  - payload of any width carried as a packed bundle;
  - valid/ready handshake in both directions;
  - synchronous flush that inserts a bubble;
  - optional 2-entry skid buffer, so ready is registered and stage-to-stage timing paths are cut.
- Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB); hazard and branch units drive flush and out_ready.

---
 rtl/syn_pipe_stage_pkg.sv | 13 +
 rtl/syn_pipe_slot.sv | 22 ++
 rtl/syn_pipe_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/syn_pipe_stage_pkg.sv
// rtl/syn_pipe_stage_pkg.sv - shared state encoding for the pipeline stage register
package syn_pipe_stage_pkg;

    // Width of the stage state; the encoding doubles as the occupancy count.
    localparam int PIPE_ST_BIT = 2;

    typedef enum logic [PIPE_ST_BIT-1:0] {
        PIPE_ST_EMPTY = 2'd0,
        PIPE_ST_ONE   = 2'd1,
        PIPE_ST_TWO   = 2'd2
    } pipe_st_e;

endpackage

// File: rtl/syn_pipe_slot.sv
// rtl/syn_pipe_slot.sv - payload register with load enable and clear-to-bubble
module syn_pipe_slot #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load so a reset/flush always leaves the bubble encoding.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= NOP_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/syn_pipe_stage.sv
// rtl/syn_pipe_stage.sv - generic valid/ready pipeline stage with flush and optional skid entry
module syn_pipe_stage
    import syn_pipe_stage_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Reset and flush have the same effect: every held entry becomes a bubble.
    logic clr;
    logic in_fire;
    logic out_fire;

    assign clr      = rst | flush;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    if (WIDTH < 1) begin : g_bad_width
        $error("syn_pipe_stage: WIDTH must be at least 1");
    end

    if (SKID != 0 && SKID != 1) begin : g_bad_skid
        $error("syn_pipe_stage: SKID must be 0 or 1");
    end

    if (SKID == 0) begin : g_single
        logic valid_q;

        syn_pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_main (
            .clk  (clk),
            .clr  (clr),
            .load (in_fire),
            .d    (in_data),
            .q    (out_data)
        );

        // Valid flag: set on accept, dropped when drained with nothing new arriving.
        always_ff @(posedge clk) begin
            if (clr) begin
                valid_q <= 1'b0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

        // Single entry can refill in the same cycle it drains, so ready follows out_ready.
        assign in_ready  = ~valid_q | out_ready;
        assign out_valid = valid_q;
        assign occupancy = {1'b0, valid_q};
    end else begin : g_skid
        pipe_st_e         st_q;
        pipe_st_e         st_nxt;
        logic             main_load;
        logic             main_from_skid;
        logic             skid_load;
        logic [WIDTH-1:0] main_d;
        logic [WIDTH-1:0] skid_q;

        assign main_d = main_from_skid ? skid_q : in_data;

        syn_pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_main (
            .clk  (clk),
            .clr  (clr),
            .load (main_load),
            .d    (main_d),
            .q    (out_data)
        );

        syn_pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_skid (
            .clk  (clk),
            .clr  (clr),
            .load (skid_load),
            .d    (in_data),
            .q    (skid_q)
        );

        // State register; unused encodings fall back to EMPTY via the next-state logic.
        always_ff @(posedge clk) begin
            if (clr) begin
                st_q <= PIPE_ST_EMPTY;
            end else begin
                st_q <= st_nxt;
            end
        end

        // Next state and register steering; the skid entry only fills when the head stalls.
        always_comb begin
            st_nxt         = st_q;
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
            case (st_q)
                PIPE_ST_EMPTY: begin
                    if (in_fire) begin
                        st_nxt    = PIPE_ST_ONE;
                        main_load = 1'b1;
                    end
                end
                PIPE_ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        st_nxt    = PIPE_ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        st_nxt = PIPE_ST_EMPTY;
                    end
                end
                PIPE_ST_TWO: begin
                    if (out_fire) begin
                        st_nxt         = PIPE_ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    st_nxt = PIPE_ST_EMPTY;
                end
            endcase
        end

        // Ready depends on state only, which cuts the out_ready -> in_ready path.
        assign in_ready  = (st_q != PIPE_ST_TWO);
        assign out_valid = (st_q != PIPE_ST_EMPTY);
        assign occupancy = st_q;
    end

endmodule
